// File: rtl/btb_param.sv
// Direct-mapped branch target buffer with per-entry saturating counters and mispredict/flush generation.
// Optional statistics counters are enabled by defining BTB_STATS_EN.
module btb_param #(
  parameter int PC_W    = 16,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            btb_prediction,
  output logic [PC_W-1:0] btb_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            r_nop
`ifdef BTB_STATS_EN
  ,
  output logic [15:0]     stat_lookups,
  output logic [15:0]     stat_hits,
  output logic [15:0]     stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic             r_valid [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [PC_W-1:0]  r_tgt   [ENTRIES];
  logic [CTR_W-1:0] r_ctr   [ENTRIES];

  logic [IDX_W-1:0] w_f_idx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic             w_br_mis;

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    if (c == CTR_MAX) return c;
    else              return c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    if (c == CTR_W'(0)) return c;
    else                return c - CTR_W'(1);
  endfunction

  assign w_f_idx  = fetch_pc[IDX_W-1:0];
  assign w_f_tag  = fetch_pc[PC_W-1:IDX_W];
  assign w_ex_idx = ex_pc[IDX_W-1:0];
  assign w_ex_tag = ex_pc[PC_W-1:IDX_W];

  // Fetch-side lookup; reads pre-update table contents (no bypass).
  always_comb begin
    w_f_hit        = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    btb_prediction = w_f_hit && r_ctr[w_f_idx][CTR_W-1];
    if (btb_prediction) btb_target = r_tgt[w_f_idx];
    else                btb_target = fetch_pc + PC_W'(1);
  end

  // Execute-side mispredict detection and redirect target.
  always_comb begin
    w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    w_br_mis = ex_is_branch &&
               ((ex_pred_taken != ex_taken) || (ex_taken && (ex_pred_target != ex_target)));
    flush    = ex_valid && (w_br_mis || (!ex_is_branch && ex_pred_taken));
    if (!flush)                       redirect_pc = {PC_W{1'b0}};
    else if (ex_taken && ex_is_branch) redirect_pc = ex_target;
    else                              redirect_pc = ex_pc + PC_W'(1);
  end

  // Table update from resolved branches; reset dominates any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
    end else if (ex_valid && ex_is_branch) begin
      if (w_ex_hit) begin
        if (ex_taken) begin
          r_ctr[w_ex_idx] <= ctr_inc(r_ctr[w_ex_idx]);
          r_tgt[w_ex_idx] <= ex_target;
        end else begin
          r_ctr[w_ex_idx] <= ctr_dec(r_ctr[w_ex_idx]);
        end
      end else if (ex_taken) begin
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= w_ex_tag;
        r_tgt[w_ex_idx]   <= ex_target;
        r_ctr[w_ex_idx]   <= CTR_WT;
      end else begin
        r_valid[w_ex_idx] <= r_valid[w_ex_idx];
      end
    end else if (ex_valid && ex_pred_taken && w_ex_hit) begin
      // A non-branch that hit in the table is a stale entry; drop it.
      r_valid[w_ex_idx] <= 1'b0;
    end else begin
      r_valid[w_ex_idx] <= r_valid[w_ex_idx];
    end
  end

  // Bubble request follows flush by one cycle.
  always_ff @(posedge clk) begin
    if (rst) r_nop <= 1'b0;
    else     r_nop <= flush;
  end

`ifdef BTB_STATS_EN
  logic [15:0] r_stat_lookups;
  logic [15:0] r_stat_hits;
  logic [15:0] r_stat_mis;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    else               return v + 16'd1;
  endfunction

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_lookups <= 16'd0;
      r_stat_hits    <= 16'd0;
      r_stat_mis     <= 16'd0;
    end else begin
      r_stat_lookups <= sat_inc16(r_stat_lookups);
      if (btb_prediction) r_stat_hits <= sat_inc16(r_stat_hits);
      else                r_stat_hits <= r_stat_hits;
      if (flush) r_stat_mis <= sat_inc16(r_stat_mis);
      else       r_stat_mis <= r_stat_mis;
    end
  end

  assign stat_lookups     = r_stat_lookups;
  assign stat_hits        = r_stat_hits;
  assign stat_mispredicts = r_stat_mis;
`endif

endmodule

// File: tb/tb_btb_param.sv
// Self-checking bench for btb_param: directed scenarios plus randomized traffic against a table model.
module tb_btb_param;
  localparam int E    = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int HALF = 1 << (CW - 1);

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fetch_pc;
  logic        btb_prediction;
  logic [15:0] btb_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [15:0] ex_pc, ex_target, ex_pred_target;
  logic        flush;
  logic [15:0] redirect_pc;
  logic        r_nop;
`ifdef BTB_STATS_EN
  logic [15:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  int checks = 0;
  int failures = 0;

  // model state: one record per index, full-PC arithmetic
  int mv[E], mtag[E], mtgt[E], mctr[E];
  int m_nop, m_lk, m_hit, m_mis;

  btb_param #(.PC_W(16), .ENTRIES(E), .CTR_W(CW)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
    .btb_prediction(btb_prediction), .btb_target(btb_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush), .redirect_pc(redirect_pc), .r_nop(r_nop)
`ifdef BTB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  function automatic int f_pred(int pc);
    int i = pc % E;
    return (mv[i] != 0 && mtag[i] == pc / E && mctr[i] >= HALF) ? 1 : 0;
  endfunction

  function automatic int f_target(int pc);
    return (f_pred(pc) != 0) ? mtgt[pc % E] : (pc + 1) % 65536;
  endfunction

  function automatic int f_flush();
    int v = int'(ex_valid), b = int'(ex_is_branch), t = int'(ex_taken), p = int'(ex_pred_taken);
    if (v == 0) return 0;
    if (b != 0) return (p != t || (t != 0 && ex_pred_target != ex_target)) ? 1 : 0;
    return p;
  endfunction

  function automatic int f_redirect();
    if (f_flush() == 0) return 0;
    if (ex_taken && ex_is_branch) return int'(ex_target);
    return (int'(ex_pc) + 1) % 65536;
  endfunction

  task automatic model_clock();
    int fl = f_flush();
    int pr = f_pred(int'(fetch_pc));
    int pc = int'(ex_pc);
    int i = pc % E;
    int hit = (mv[i] != 0 && mtag[i] == pc / E) ? 1 : 0;
    if (rst) begin
      for (int k = 0; k < E; k++) begin mv[k] = 0; mctr[k] = HALF - 1; end
      m_nop = 0; m_lk = 0; m_hit = 0; m_mis = 0;
    end else begin
      m_nop = fl;
      if (m_lk < 65535) m_lk++;
      if (pr != 0 && m_hit < 65535) m_hit++;
      if (fl != 0 && m_mis < 65535) m_mis++;
      if (ex_valid && ex_is_branch) begin
        if (hit != 0 && ex_taken) begin
          mctr[i] = (mctr[i] + 1 > CMAX) ? CMAX : mctr[i] + 1;
          mtgt[i] = int'(ex_target);
        end else if (hit != 0) begin
          mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
        end else if (ex_taken) begin
          mv[i] = 1; mtag[i] = pc / E; mtgt[i] = int'(ex_target); mctr[i] = HALF;
        end
      end else if (ex_valid && ex_pred_taken && hit != 0) begin
        mv[i] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
    ex_pc = 16'h0; ex_target = 16'h0; ex_pred_target = 16'h0;
  endtask

  task automatic set_branch(int pc, int taken, int tgt);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 16'(pc);
    ex_taken = taken[0]; ex_target = 16'(tgt);
    ex_pred_taken = f_pred(pc) != 0; ex_pred_target = 16'(f_target(pc));
  endtask

  task automatic do_branch(int pc, int taken, int tgt);
    set_branch(pc, taken, tgt);
    cycle();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); fetch_pc = 16'h0;
    cycle(); cycle();
    rst = 1'b0;
    for (int pc = 0; pc <= 32; pc++) begin
      fetch_pc = 16'(pc);
      @(negedge clk);
      checks++;
      if (btb_prediction !== 1'b0 || btb_target !== 16'(pc + 1) || r_nop !== 1'b0) begin
        failures++;
        $display("FAIL reset_sweep pc=%h got pred=%b tgt=%h nop=%b want 0/%h/0",
                 pc, btb_prediction, btb_target, r_nop, 16'(pc + 1));
      end
      cycle();
    end
  endtask

  task automatic test_taken_alloc();
    fetch_pc = 16'h0040;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 16'h0002; ex_taken = 1'b1;
    ex_target = 16'h0010; ex_pred_taken = 1'b0; ex_pred_target = 16'h0003;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 16'h0010 || r_nop !== 1'b0) begin
      failures++;
      $display("FAIL alloc_flush got flush=%b redir=%h nop=%b want 1/0010/0", flush, redirect_pc, r_nop);
    end
    cycle(); idle(); fetch_pc = 16'h0002;
    @(negedge clk);
    checks++;
    if (r_nop !== 1'b1 || btb_prediction !== 1'b1 || btb_target !== 16'h0010 || flush !== 1'b0) begin
      failures++;
      $display("FAIL alloc_lookup got nop=%b pred=%b tgt=%h flush=%b want 1/1/0010/0",
               r_nop, btb_prediction, btb_target, flush);
    end
    cycle();
    @(negedge clk);
    checks++;
    if (r_nop !== 1'b0) begin
      failures++;
      $display("FAIL nop_one_cycle got nop=%b want 0", r_nop);
    end
  endtask

  task automatic test_counter();
    int exp_seq[4] = '{0, 1, 0, 1};
    for (int k = 0; k < 4; k++) begin
      do_branch(2, k % 2, 16'h0010);
      fetch_pc = 16'h0002;
      @(negedge clk);
      checks++;
      if (btb_prediction !== exp_seq[k][0]) begin
        failures++;
        $display("FAIL ctr_toggle step=%0d got pred=%b want %0d", k, btb_prediction, exp_seq[k]);
      end
    end
    for (int k = 0; k < 4; k++) do_branch(2, 1, 16'h0010);
    do_branch(2, 0, 16'h0010);
    @(negedge clk);
    checks++;
    if (btb_prediction !== 1'b1) begin
      failures++;
      $display("FAIL ctr_sat_high got pred=%b want 1", btb_prediction);
    end
    for (int k = 0; k < 4; k++) do_branch(2, 0, 16'h0010);
    do_branch(2, 1, 16'h0010);
    @(negedge clk);
    checks++;
    if (btb_prediction !== 1'b0) begin
      failures++;
      $display("FAIL ctr_sat_low got pred=%b want 0", btb_prediction);
    end
  endtask

  task automatic test_alias();
    do_branch(16'h0012, 1, 16'h0030);
    fetch_pc = 16'h0002;
    @(negedge clk);
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'h0003) begin
      failures++;
      $display("FAIL alias_old got pred=%b tgt=%h want 0/0003", btb_prediction, btb_target);
    end
    fetch_pc = 16'h0012; #1;
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h0030) begin
      failures++;
      $display("FAIL alias_new got pred=%b tgt=%h want 1/0030", btb_prediction, btb_target);
    end
  endtask

  task automatic test_same_cycle();
    cycle();
    fetch_pc = 16'h0002;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 16'h0002; ex_taken = 1'b1;
    ex_target = 16'h0044; ex_pred_taken = 1'b0; ex_pred_target = 16'h0003;
    @(negedge clk);
    checks++;
    if (btb_prediction !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_old got pred=%b want 0", btb_prediction);
    end
    cycle(); idle();
    @(negedge clk);
    checks++;
    if (btb_prediction !== 1'b1 || btb_target !== 16'h0044) begin
      failures++;
      $display("FAIL same_cycle_new got pred=%b tgt=%h want 1/0044", btb_prediction, btb_target);
    end
    set_branch(16'h0002, 1, 16'h0050);
    rst = 1'b1;
    cycle(); rst = 1'b0; idle();
    @(negedge clk);
    checks++;
    if (btb_prediction !== 1'b0 || btb_target !== 16'h0003) begin
      failures++;
      $display("FAIL rst_over_update got pred=%b tgt=%h want 0/0003", btb_prediction, btb_target);
    end
  endtask

  task automatic test_nonbranch();
    do_branch(16'h0025, 1, 16'h0060);
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 16'h0025; ex_taken = 1'b0;
    ex_target = 16'h0000; ex_pred_taken = 1'b1; ex_pred_target = 16'h0060;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 16'h0026) begin
      failures++;
      $display("FAIL nonbranch_flush got flush=%b redir=%h want 1/0026", flush, redirect_pc);
    end
    cycle(); idle(); fetch_pc = 16'h0025;
    @(negedge clk);
    checks++;
    if (btb_prediction !== 1'b0 || r_nop !== 1'b1) begin
      failures++;
      $display("FAIL nonbranch_inval got pred=%b nop=%b want 0/1", btb_prediction, r_nop);
    end
  endtask

  task automatic test_wrap();
    fetch_pc = 16'hFFFF;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = 16'hFFFF; ex_taken = 1'b0;
    ex_target = 16'h1234; ex_pred_taken = 1'b1; ex_pred_target = 16'h1234;
    @(negedge clk);
    checks++;
    if (btb_target !== 16'h0000 || flush !== 1'b1 || redirect_pc !== 16'h0000) begin
      failures++;
      $display("FAIL wrap got tgt=%h flush=%b redir=%h want 0000/1/0000", btb_target, flush, redirect_pc);
    end
    cycle(); idle();
  endtask

  function automatic int rnd_pc();
    if ($urandom_range(0, 9) == 0) return 16'hFFFF;
    return $urandom_range(0, 3) * E + $urandom_range(0, 3);
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int pc = rnd_pc();
      rst = ($urandom_range(0, 59) == 0);
      fetch_pc = 16'(rnd_pc());
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_is_branch = ($urandom_range(0, 2) != 0);
      ex_pc = 16'(pc);
      ex_taken = $urandom_range(0, 1) != 0;
      ex_target = 16'($urandom_range(1, 2) * 256);
      ex_pred_taken = ($urandom_range(0, 9) < 7) ? (f_pred(pc) != 0) : ($urandom_range(0, 1) != 0);
      ex_pred_target = ($urandom_range(0, 9) < 7) ? 16'(f_target(pc)) : 16'h0100;
      @(negedge clk);
      checks++;
      if (btb_prediction !== f_pred(int'(fetch_pc)) || btb_target !== 16'(f_target(int'(fetch_pc))) ||
          flush !== f_flush() || redirect_pc !== 16'(f_redirect()) || r_nop !== m_nop[0]) begin
        failures++;
        $display("FAIL random n=%0d got pred=%b tgt=%h flush=%b redir=%h nop=%b want %0d/%h/%0d/%h/%0d",
                 n, btb_prediction, btb_target, flush, redirect_pc, r_nop,
                 f_pred(int'(fetch_pc)), 16'(f_target(int'(fetch_pc))), f_flush(), 16'(f_redirect()), m_nop);
      end
`ifdef BTB_STATS_EN
      checks++;
      if (stat_lookups !== 16'(m_lk) || stat_hits !== 16'(m_hit) || stat_mispredicts !== 16'(m_mis)) begin
        failures++;
        $display("FAIL stats n=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 n, stat_lookups, stat_hits, stat_mispredicts, m_lk, m_hit, m_mis);
      end
`endif
      cycle();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    rst = 1'b1; fetch_pc = 16'h0; idle();
    for (int k = 0; k < E; k++) begin mv[k] = 0; mtag[k] = 0; mtgt[k] = 0; mctr[k] = HALF - 1; end
    m_nop = 0; m_lk = 0; m_hit = 0; m_mis = 0;
    test_reset();
    test_taken_alloc();
    test_counter();
    test_alias();
    test_same_cycle();
    test_nonbranch();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btb_param.md
Name: btb_param

Overview:
- Parametrised, direct-mapped branch target buffer for the 16-bit pipelined core, successor to the fixed single-entry BTB.
- Sits between fetch and execute:
  - Fetch side: same-cycle lookup of taken/target prediction for fetch_pc.
  - Execute side: resolved branch outcomes update per-entry tag, target and N-bit saturating counter.
  - Mispredict/flush signalling and registered bubble request (r_nop) are generated here.

Parameters:
- PC_W, 16, PC and target width (word-addressed PC, sequential next = pc+1).
- ENTRIES, 16, table depth; power of two, 2..256; IDX_W = log2(ENTRIES).
- CTR_W, 2, saturating-counter width, 1..4.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous active-high reset.
- fetch_pc  in  PC_W  PC being fetched this cycle.
- btb_prediction  out  1  1 = predict taken for fetch_pc (combinational).
- btb_target  out  PC_W  predicted next PC: stored target if predicted taken, else fetch_pc+1 (combinational).
- ex_valid  in  1  execute stage holds a valid instruction.
- ex_is_branch  in  1  instruction in execute is a conditional branch.
- ex_pc  in  PC_W  PC of the execute-stage instruction.
- ex_taken  in  1  resolved outcome, from flags.
- ex_target  in  PC_W  resolved branch target (target_entry).
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  PC_W  predicted target carried down the pipe.
- flush  out  1  mispredict this cycle (combinational).
- redirect_pc  out  PC_W  correct next PC when flush=1, else 0.
- r_nop  out  1  registered copy of flush: high exactly one cycle after flush.

Behaviour:
- Entry contents: valid, tag = pc[PC_W-1:IDX_W], target[PC_W], ctr[CTR_W]. Index = pc[IDX_W-1:0].
- Reset (rst=1 at posedge):
  - all valid=0; every ctr = 2^(CTR_W-1)-1 (weakly not-taken).
  - r_nop=0; stats counters 0.
  - rst has priority over any simultaneous update.
- Lookup (combinational):
  - hit = valid[idx] & tag match.
  - btb_prediction = hit & ctr[idx] MSB.
  - btb_target = btb_prediction ? target[idx] : fetch_pc+1, modulo 2^PC_W (0xFFFF+1 wraps to 0x0000).
- Update, at posedge when ex_valid & ex_is_branch & !rst:
  - Entry hit, taken: ctr saturating +1 (max 2^CTR_W-1); target <= ex_target.
  - Entry hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate/replace the entry. valid=1, tag, target=ex_target, ctr = 2^(CTR_W-1) (weakly taken).
  - Miss, not taken: no change.
- Non-branch predicted taken (ex_valid & !ex_is_branch & ex_pred_taken): that entry is invalidated if its tag matches.
- Mispredict:
  - flush = ex_valid & ( (ex_is_branch & (ex_pred_taken != ex_taken | (ex_taken & ex_pred_target != ex_target))) | (!ex_is_branch & ex_pred_taken) ).
  - redirect_pc = ex_taken&ex_is_branch ? ex_target : ex_pc+1, valid only while flush=1.
- r_nop <= flush every cycle (cleared by rst).
- Same-cycle lookup and update at the same index: lookup returns pre-update contents (no bypass); the new value is visible from the next cycle.
- ex_valid=0: no table change, flush=0.

Optional Feature:
- Macro BTB_STATS_EN.
- When defined: adds outputs stat_lookups, stat_hits, stat_mispredicts (16 bits each, saturating at 0xFFFF, cleared by rst).
  - stat_lookups increments every non-reset cycle.
  - stat_hits increments when btb_prediction=1.
  - stat_mispredicts increments when flush=1.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then fetch_pc sweep 0x0000..0x0020 -> btb_prediction=0; btb_target=fetch_pc+1 each cycle; r_nop=0.
- Taken branch ex_pc=0x0002, ex_target=0x0010, ex_pred_taken=0 -> flush=1, redirect_pc=0x0010, r_nop=1 next cycle only. Next cycle, fetch_pc=0x0002 -> prediction=1, target=0x0010.
- Same branch alternates not-taken/taken (zflag toggling) with CTR_W=2 -> ctr sequence 2,1,2,1; prediction follows MSB (1,0,1,0); saturation confirmed at 3 after four consecutive taken and at 0 after four consecutive not-taken.
- Aliasing, ENTRIES=16: taken branch at 0x0012 after entry 0x0002 -> entry replaced. fetch_pc=0x0002 -> prediction=0; fetch_pc=0x0012 -> prediction=1.
- Update of idx 2 while fetch_pc=0x0002 in the same cycle -> old prediction that cycle, new prediction next. rst asserted during an update cycle -> entry invalid afterwards.
- BTB_STATS_EN: 10 lookup cycles with 3 hits and 2 flushes -> stat_lookups=10, stat_hits=3, stat_mispredicts=2. Counters hold at 0xFFFF when forced.
